// File: rtl/lcl_mem_responder.sv
// rtl/lcl_mem_responder.sv - local burst interface responder backed by a simple-dual-port line memory
module lcl_mem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int LINE_LOG2  = 6,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lcl_ostart,
    input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
    input  logic [7:0]            lcl_onum,
    output logic                  lcl_obusy,
    output logic                  lcl_ordy,
    input  logic                  lcl_rden,
    output logic                  lcl_dv,
    output logic [DATA_WIDTH-1:0] lcl_dout,
    output logic                  lcl_odone,
    input  logic                  lcl_istart,
    input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
    input  logic [7:0]            lcl_inum,
    output logic                  lcl_ibusy,
    output logic                  lcl_irdy,
    input  logic                  lcl_den,
    input  logic [DATA_WIDTH-1:0] lcl_din,
    input  logic                  lcl_idone,
    output logic                  err_overrun
);
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT_DONE} wstate_t;

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    rstate_t               r_rstate, w_rstate_nxt;
    wstate_t               r_wstate, w_wstate_nxt;
    logic [DEPTH_LOG2-1:0] r_rbase, r_wbase;
    logic [8:0]            r_rnum, r_rissued, r_wnum, r_wcnt;
    logic                  r_wdone_seen, r_dv, r_err;
    logic [DATA_WIDTH-1:0] r_dout;

    logic                  w_ordy, w_irdy;
    logic                  w_rd_acc, w_rd_last, w_wr_acc, w_wr_last, w_done_any;
    logic [DEPTH_LOG2-1:0] w_rd_line, w_wr_line;
    logic                  w_unused_addr;

    // Only the line-index field of each address matters; the rest is don't-care.
    assign w_unused_addr = ^{lcl_oaddr, lcl_iaddr};

    assign w_rd_acc   = lcl_rden && w_ordy;
    assign w_rd_last  = w_rd_acc && (r_rissued == r_rnum - 9'd1);
    assign w_rd_line  = r_rbase + DEPTH_LOG2'(r_rissued);
    assign w_wr_acc   = lcl_den && w_irdy;
    assign w_wr_last  = w_wr_acc && (r_wcnt == r_wnum - 9'd1);
    assign w_wr_line  = r_wbase + DEPTH_LOG2'(r_wcnt);
    assign w_done_any = r_wdone_seen || lcl_idone;

    // Read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (lcl_ostart) w_rstate_nxt = R_ISSUE;
            R_ISSUE: if (w_rd_last)  w_rstate_nxt = R_DRAIN;
            R_DRAIN: w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        lcl_obusy = (r_rstate != R_IDLE);
        w_ordy    = (r_rstate == R_ISSUE);
        lcl_odone = (r_rstate == R_DRAIN);
    end
    assign lcl_ordy = w_ordy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbase   <= '0;
            r_rnum    <= '0;
            r_rissued <= '0;
            r_dv      <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_dv <= w_rd_acc;
            if (r_rstate == R_IDLE && lcl_ostart) begin
                r_rbase   <= lcl_oaddr[LINE_LOG2+DEPTH_LOG2-1:LINE_LOG2];
                r_rnum    <= (lcl_onum == 8'd0) ? 9'd256 : {1'b0, lcl_onum};
                r_rissued <= '0;
            end else if (w_rd_acc) begin
                r_rissued <= r_rissued + 9'd1;
            end
            // Same-edge write to this line lands after this read: read-first.
            if (w_rd_acc) r_dout <= r_mem[w_rd_line];
        end
    end
    assign lcl_dv   = r_dv;
    assign lcl_dout = r_dout;

    // Write FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:      if (lcl_istart) w_wstate_nxt = W_DATA;
            W_DATA:      if (w_wr_last)  w_wstate_nxt = w_done_any ? W_IDLE : W_WAIT_DONE;
            W_WAIT_DONE: if (w_done_any) w_wstate_nxt = W_IDLE;
            default:     w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        lcl_ibusy = (r_wstate != W_IDLE);
        w_irdy    = (r_wstate == W_DATA);
    end
    assign lcl_irdy = w_irdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbase      <= '0;
            r_wnum       <= '0;
            r_wcnt       <= '0;
            r_wdone_seen <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE) begin
                if (lcl_istart) begin
                    r_wbase      <= lcl_iaddr[LINE_LOG2+DEPTH_LOG2-1:LINE_LOG2];
                    r_wnum       <= (lcl_inum == 8'd0) ? 9'd256 : {1'b0, lcl_inum};
                    r_wcnt       <= '0;
                    r_wdone_seen <= 1'b0;
                end
            end else begin
                if (lcl_idone) r_wdone_seen <= 1'b1;
                if (w_wr_acc)  r_wcnt <= r_wcnt + 9'd1;
            end
            if (lcl_den && !w_irdy) r_err <= 1'b1;
        end
    end
    assign err_overrun = r_err;

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_wr_line] <= lcl_din;
    end
endmodule

// File: tb/tb_lcl_mem_responder.sv
// tb/tb_lcl_mem_responder.sv - randomized self-checking bench for lcl_mem_responder
module tb_lcl_mem_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         lcl_ostart, lcl_obusy, lcl_ordy, lcl_rden, lcl_dv, lcl_odone;
    logic [63:0]  lcl_oaddr, lcl_iaddr;
    logic [7:0]   lcl_onum, lcl_inum;
    logic [511:0] lcl_dout, lcl_din;
    logic         lcl_istart, lcl_ibusy, lcl_irdy, lcl_den, lcl_idone, err_overrun;

    logic [511:0] ref_mem [1024];
    logic         exp_err;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           rw_n, rr_n, rw_k, rw_x, rw_p, rr_p;
    logic [63:0]  rw_a, rr_a;
    logic [511:0] rst_d0, rst_d1;

    lcl_mem_responder dut (
        .clk(clk), .rst(rst),
        .lcl_ostart(lcl_ostart), .lcl_oaddr(lcl_oaddr), .lcl_onum(lcl_onum),
        .lcl_obusy(lcl_obusy), .lcl_ordy(lcl_ordy), .lcl_rden(lcl_rden),
        .lcl_dv(lcl_dv), .lcl_dout(lcl_dout), .lcl_odone(lcl_odone),
        .lcl_istart(lcl_istart), .lcl_iaddr(lcl_iaddr), .lcl_inum(lcl_inum),
        .lcl_ibusy(lcl_ibusy), .lcl_irdy(lcl_irdy), .lcl_den(lcl_den),
        .lcl_din(lcl_din), .lcl_idone(lcl_idone), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Write burst; called at posedge+1. done_k: idone is raised once this many dens were sent.
    task automatic do_write(input logic [63:0] addr, input int num8, input int done_k,
                            input int extra, input int prob);
        int n, cnt, sent, cyc;
        logic [9:0] base;
        logic busy, dseen, isent, d, dn;
        logic [511:0] din;
        n = (num8 == 0) ? 256 : num8;
        base = addr[15:6];
        lcl_istart = 1'b1; lcl_iaddr = addr; lcl_inum = 8'(num8);
        @(posedge clk); #1;
        lcl_istart = 1'b0;
        busy = 1'b1; dseen = 1'b0; isent = 1'b0; cnt = 0; sent = 0; cyc = 0;
        check("ibusy_start", lcl_ibusy, 1'b1);
        check("irdy_start", lcl_irdy, 1'b1);
        while ((busy || sent < n + extra) && cyc < 3000) begin
            d = 1'b0; dn = 1'b0; din = '0;
            if (!isent && sent >= done_k) begin
                dn = 1'b1; isent = 1'b1;
            end else if (sent < n + extra && $urandom_range(99) < prob) begin
                d = 1'b1; din = rand_line(); sent++;
            end
            lcl_den = d; lcl_din = din; lcl_idone = dn;
            @(posedge clk); #1;
            if (d) begin
                if (busy && cnt < n) begin
                    ref_mem[(int'(base) + cnt) % 1024] = din;
                    cnt++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (dn && busy) dseen = 1'b1;
            if (busy && cnt == n && dseen) busy = 1'b0;
            check("ibusy", lcl_ibusy, busy);
            check("irdy", lcl_irdy, busy && cnt < n);
            check("err_overrun", err_overrun, exp_err);
            cyc++;
        end
        lcl_den = 1'b0; lcl_idone = 1'b0;
        check("write_done", lcl_ibusy, 1'b0);
    endtask

    // Read burst; called at posedge+1, drives at posedge+2 so same-edge writes are modelled read-first.
    task automatic do_read(input logic [63:0] addr, input int num8, input int prob,
                           input logic [31:0] pat, input int pat_len, input int restart_at);
        int n, issued, cyc;
        logic [9:0] base;
        logic busy, fin_prev, r, acc, last;
        logic [511:0] snap;
        n = (num8 == 0) ? 256 : num8;
        base = addr[15:6];
        snap = '0;
        #1;
        lcl_ostart = 1'b1; lcl_oaddr = addr; lcl_onum = 8'(num8);
        @(posedge clk); #1;
        lcl_ostart = 1'b0;
        busy = 1'b1; fin_prev = 1'b0; issued = 0; cyc = 0;
        check("obusy_start", lcl_obusy, 1'b1);
        check("ordy_start", lcl_ordy, 1'b1);
        while ((busy || cyc < pat_len) && cyc < 3000) begin
            #1;
            if (pat_len > 0) r = (cyc < pat_len) ? pat[cyc] : 1'b0;
            else             r = ($urandom_range(99) < prob);
            acc = r && busy && (issued < n);
            if (acc) begin
                snap = ref_mem[(int'(base) + issued) % 1024];
                issued++;
            end
            last = acc && (issued == n);
            if (cyc == restart_at && busy) begin
                lcl_ostart = 1'b1; lcl_oaddr = {$urandom, $urandom}; lcl_onum = 8'($urandom);
            end
            lcl_rden = r;
            @(posedge clk); #1;
            lcl_ostart = 1'b0;
            if (fin_prev) busy = 1'b0;
            check("dv", lcl_dv, acc);
            if (acc) check("dout", lcl_dout, snap);
            check("odone", lcl_odone, last);
            check("obusy", lcl_obusy, busy);
            check("ordy", lcl_ordy, busy && issued < n);
            fin_prev = last;
            cyc++;
        end
        lcl_rden = 1'b0;
        check("read_done", lcl_obusy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; exp_err = 1'b0;
        lcl_ostart = 0; lcl_oaddr = 0; lcl_onum = 0; lcl_rden = 0;
        lcl_istart = 0; lcl_iaddr = 0; lcl_inum = 0; lcl_den = 0; lcl_din = 0; lcl_idone = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_obusy", lcl_obusy, 1'b0);
        check("rst_ordy", lcl_ordy, 1'b0);
        check("rst_dv", lcl_dv, 1'b0);
        check("rst_dout", lcl_dout, '0);
        check("rst_odone", lcl_odone, 1'b0);
        check("rst_ibusy", lcl_ibusy, 1'b0);
        check("rst_irdy", lcl_irdy, 1'b0);
        check("rst_err", err_overrun, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill all 1024 lines so every later read has a known reference
        for (int i = 0; i < 4; i++) do_write(64'(i) * 64'h4000, 0, 256, 0, 100);

        // Write/read-back, idone after the last beat, rden held high
        do_write(64'h100, 4, 4, 0, 100);
        do_read(64'h100, 4, 100, 32'h0, 0, -1);

        // Gapped rden with one overshoot beat after ordy drops
        do_read(64'h100, 3, 0, 32'b111001, 6, -1);
        check("gap_no_err", err_overrun, 1'b0);

        // num=0 starting at the last line wraps to line 0
        do_write(64'hFFC0, 0, $urandom_range(256), 0, 70);
        do_read(64'hFFC0, 2, 100, 32'h0, 0, -1);
        do_read(64'h0FFC0 + 64'h1_0000, 0, 80, 32'h0, 0, -1);

        // Overrun: two beats expected, three sent, idone before the first
        do_write(64'h2000, 2, 0, 1, 100);
        check("overrun_err", err_overrun, 1'b1);
        do_read(64'h2000, 3, 100, 32'h0, 0, -1);

        // Second ostart during an active read is ignored
        do_read(64'h3040, 5, 60, 32'h0, 0, 1);

        // Simultaneous read and write of the same lines return old data
        fork
            do_write(64'h4000, 4, 4, 0, 100);
            do_read(64'h4000, 4, 100, 32'h0, 0, -1);
        join
        do_read(64'h4000, 4, 100, 32'h0, 0, -1);

        // Random concurrent bursts
        for (int it = 0; it < 8; it++) begin
            rw_a = {$urandom, $urandom}; rr_a = {$urandom, $urandom};
            rw_n = $urandom_range(24, 1); rr_n = $urandom_range(24, 1);
            rw_k = $urandom_range(rw_n);  rw_x = ($urandom_range(3) == 0) ? 1 : 0;
            rw_p = $urandom_range(100, 40); rr_p = $urandom_range(100, 40);
            if (it == 3) rr_a = rw_a;
            fork
                do_write(rw_a, rw_n, rw_k, rw_x, rw_p);
                do_read(rr_a, rr_n, rr_p, 32'h0, 0, -1);
            join
        end

        // Reset in the middle of a 4-beat write and a 4-beat read
        lcl_istart = 1'b1; lcl_iaddr = 64'h8000; lcl_inum = 8'd4;
        lcl_ostart = 1'b1; lcl_oaddr = 64'h9000; lcl_onum = 8'd4;
        @(posedge clk); #1;
        lcl_istart = 1'b0; lcl_ostart = 1'b0;
        rst_d0 = rand_line(); rst_d1 = rand_line();
        lcl_den = 1'b1; lcl_din = rst_d0; lcl_rden = 1'b1;
        @(posedge clk); #1;
        ref_mem[512] = rst_d0;
        lcl_din = rst_d1;
        @(posedge clk); #1;
        ref_mem[513] = rst_d1;
        check("pre_rst_dv", lcl_dv, 1'b1);
        lcl_din = rand_line();
        #2;
        rst = 1'b1;
        #1;
        check("arst_obusy", lcl_obusy, 1'b0);
        check("arst_ordy", lcl_ordy, 1'b0);
        check("arst_dv", lcl_dv, 1'b0);
        check("arst_dout", lcl_dout, '0);
        check("arst_odone", lcl_odone, 1'b0);
        check("arst_ibusy", lcl_ibusy, 1'b0);
        check("arst_irdy", lcl_irdy, 1'b0);
        check("arst_err", err_overrun, 1'b0);
        lcl_den = 1'b0; lcl_rden = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(64'h8000, 4, 100, 32'h0, 0, -1);
        do_write(64'h9000, 4, 2, 0, 100);
        do_read(64'h9000, 4, 70, 32'h0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
